alu_control_unit: RTL and testbench

Sequencing FSM directly upstream of `arithmetic_unit`: accepts an operation request, then drives the datapath control word `c[7:0]` cycle by cycle until the result is ready. Add/sub complete in one step. Multiply uses radix-2 Booth over 8 iterations. Division uses unsigned restoring division over 8 iterations. Datapath status bits (Q0, Q-1, A sign, M==0) feed back into the block to steer each iteration.

---
 rtl/alu_control_unit.sv | 87 ++++++++
 tb/tb_alu_control_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_control_unit.sv
// alu_control_unit: sequencing FSM driving the arithmetic_unit control word for add/sub, Booth multiply and restoring divide
module alu_control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       q0,
  input  logic       qm1,
  input  logic       a_msb,
  input  logic       m_zero,
  output logic [7:0] c,
  output logic       busy,
  output logic       done,
  output logic       div_err
);
  typedef enum logic [2:0] {IDLE, INIT, EVAL, SHIFT, LSH, SUB, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [2:0] cnt_q, cnt_d;
  logic err_q, err_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= 2'b00;
      cnt_q <= 3'd0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    err_d = err_q;
    c = 8'h00;
    case (state_q)
      IDLE: if (start) begin
        op_d = op;
        state_d = op[1] ? INIT : DONE;
      end
      INIT: begin
        c[4] = 1'b1;
        cnt_d = 3'd0;
        err_d = (op_q == 2'b11) & m_zero;
        state_d = (op_q == 2'b10) ? EVAL : (m_zero ? DONE : LSH);
      end
      EVAL: begin
        c[0] = q0 ^ qm1;
        c[1] = q0 & ~qm1;
        state_d = SHIFT;
      end
      SHIFT: begin
        c[3] = 1'b1;
        cnt_d = cnt_q + 3'd1;
        state_d = (cnt_q == 3'd7) ? DONE : EVAL;
      end
      LSH: begin
        c[2] = 1'b1;
        state_d = SUB;
      end
      SUB: begin
        c[0] = 1'b1;
        c[1] = 1'b1;
        state_d = FIX;
      end
      FIX: begin
        c[0] = a_msb;
        c[5] = ~a_msb;
        cnt_d = cnt_q + 3'd1;
        state_d = (cnt_q == 3'd7) ? DONE : LSH;
      end
      DONE: begin
        c[6] = 1'b1;
        err_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign div_err = done & err_q;
endmodule

// File: tb/tb_alu_control_unit.sv
// tb_alu_control_unit: datapath model plus per-cycle scoreboard of expected control words derived from the arithmetic
module tb_alu_control_unit;
  logic clk = 0, rst, start;
  logic [1:0] op;
  logic q0, qm1, a_msb, m_zero;
  logic [7:0] c;
  logic busy, done, div_err;
  logic [7:0] x_in, y_in;
  logic [7:0] a_r = 0, q_r = 0, m_r = 0;
  logic qm1_r = 0;
  int checks = 0, errors = 0;
  typedef struct {logic [7:0] c; logic busy; logic done; logic err;} exp_t;
  exp_t sq[$];
  exp_t cur = '{8'h00, 1'b0, 1'b0, 1'b0};
  localparam exp_t IDLE_E = '{8'h00, 1'b0, 1'b0, 1'b0};

  alu_control_unit dut (.clk(clk), .rst(rst), .start(start), .op(op), .q0(q0), .qm1(qm1),
    .a_msb(a_msb), .m_zero(m_zero), .c(c), .busy(busy), .done(done), .div_err(div_err));

  always #5 clk = ~clk;

  assign q0 = q_r[0];
  assign qm1 = qm1_r;
  assign a_msb = a_r[7];
  assign m_zero = (y_in == 8'd0);

  // Datapath reacting to the control word
  always @(posedge clk) begin
    if (c[4]) begin
      a_r <= 0; qm1_r <= 0; q_r <= x_in; m_r <= y_in;
    end else if (c[0]) a_r <= c[1] ? a_r - m_r : a_r + m_r;
    else if (c[2]) {a_r, q_r} <= {a_r, q_r} << 1;
    else if (c[3]) begin
      a_r <= {a_r[7], a_r[7:1]}; q_r <= {a_r[0], q_r[7:1]}; qm1_r <= q_r[0];
    end else if (c[5]) q_r[0] <= 1'b1;
  end

  function automatic exp_t e(input logic [7:0] cv, input logic d, input logic er);
    return '{cv, 1'b1, d, er};
  endfunction

  task automatic build(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    int rem;
    logic prev;
    if (!o[1]) begin
      sq.push_back(e(8'h40, 1, 0));
      return;
    end
    sq.push_back(e(8'h10, 0, 0));
    if (o == 2'b10) begin
      prev = 0;
      for (int i = 0; i < 8; i++) begin
        sq.push_back(e((x[i] && !prev) ? 8'h03 : (!x[i] && prev) ? 8'h01 : 8'h00, 0, 0));
        sq.push_back(e(8'h08, 0, 0));
        prev = x[i];
      end
    end else if (y != 0) begin
      rem = 0;
      for (int i = 7; i >= 0; i--) begin
        rem = rem * 2 + int'(x[i]);
        sq.push_back(e(8'h04, 0, 0));
        sq.push_back(e(8'h03, 0, 0));
        if (rem >= int'(y)) begin
          rem -= int'(y);
          sq.push_back(e(8'h20, 0, 0));
        end else sq.push_back(e(8'h01, 0, 0));
      end
    end
    sq.push_back(e(8'h40, 1, y == 0 && o == 2'b11));
  endtask

  always @(posedge clk) begin
    if (rst) begin
      sq.delete();
      cur = IDLE_E;
    end else if (!cur.busy && start) begin
      build(op, x_in, y_in);
      cur = sq.pop_front();
    end else cur = (sq.size() > 0) ? sq.pop_front() : IDLE_E;
  end

  always @(negedge clk) begin
    checks++;
    if (c !== cur.c || busy !== cur.busy || done !== cur.done || div_err !== cur.err) begin
      errors++;
      $display("FAIL ctrl t=%0t got c=%h busy=%b done=%b err=%b, expected c=%h busy=%b done=%b err=%b",
        $time, c, busy, done, div_err, cur.c, cur.busy, cur.done, cur.err);
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [7:0] xv, input logic [7:0] yv,
                        input int lat, input logic er);
    int k;
    logic seen, err_seen;
    @(posedge clk); #2;
    x_in = xv; y_in = yv; op = o; start = 1;
    @(posedge clk); #2;
    start = 0;
    k = 0; seen = 0; err_seen = 0;
    while (k < 100 && !seen) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) begin seen = 1; err_seen = div_err; end
    end
    chk("latency", seen ? 16'(k) : 16'hFFFF, 16'(lat));
    chk("div_err", {15'd0, err_seen}, {15'd0, er});
  endtask

  initial begin
    int ones;
    rst = 1; start = 0; op = 0; x_in = 0; y_in = 1;
    build(2'b10, 8'hF9, 8'd5);
    chk("mul_script_len", 16'(sq.size()), 16'd18);
    chk("mul_it0_sub", {8'd0, sq[1].c}, 16'h0003);
    chk("mul_it1_add", {8'd0, sq[3].c}, 16'h0001);
    sq.delete();
    build(2'b11, 8'd200, 8'd7);
    chk("div_script_len", 16'(sq.size()), 16'd26);
    ones = 0;
    foreach (sq[i]) if (sq[i].c == 8'h20) ones++;
    chk("div_q_ones", 16'(ones), 16'd3);
    sq.delete();
    repeat (3) @(posedge clk);
    #2 rst = 0;
    run_op(2'b00, 8'd3, 8'd4, 1, 0);
    run_op(2'b01, 8'd3, 8'd4, 1, 0);
    run_op(2'b10, 8'hF9, 8'd5, 18, 0);
    chk("mul_z", {a_r, q_r}, 16'hFFDD);
    run_op(2'b11, 8'd200, 8'd7, 26, 0);
    chk("div_q", {8'd0, q_r}, 16'd28);
    chk("div_a", {8'd0, a_r}, 16'd4);
    run_op(2'b11, 8'd200, 8'd0, 2, 1);
    @(posedge clk); #2;
    x_in = 8'hF9; y_in = 8'd5; op = 2'b10; start = 1;
    @(posedge clk); #2;
    start = 0;
    repeat (7) @(posedge clk);
    #2 rst = 1;
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_c", {8'd0, c}, 16'd0);
    run_op(2'b10, 8'hF9, 8'd5, 18, 0);
    chk("mul_z_after_rst", {a_r, q_r}, 16'hFFDD);
    @(posedge clk); #2;
    x_in = 8'hF9; y_in = 8'd5; op = 2'b00; start = 1;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #2;
      op = op + 2'd1;
    end
    start = 0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
